// File: rtl/ifetch_unit.sv
// Instruction-fetch / program-counter unit: fetches one instruction per execute slot
// over a ready handshake, resolves branch/jal/jalr targets and traps on misaligned targets.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        hold,
  input  logic        branch,
  input  logic        jal,
  input  logic        jalr,
  input  logic        zero,
  input  logic [31:0] alu_result,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        trap,
  output logic [31:0] trap_pc,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_TRAP  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] target;
  logic        fetch_done;
  logic        retire;
  logic        misaligned;

  assign pc_plus4    = pc + 32'd4;
  assign imem_addr   = pc;
  assign imem_req    = (state == S_FETCH);
  assign instr_valid = (state == S_EXEC);

  // jalr has priority over jal/branch; jalr clears bit 0 of its target.
  always_comb begin
    if (jalr)
      target = {alu_result[31:1], 1'b0};
    else if ((branch && zero) || jal)
      target = pc + alu_result;
    else
      target = pc_plus4;
  end

  assign fetch_done = (state == S_FETCH) && imem_ready;
  assign retire     = (state == S_EXEC) && !hold;
  assign misaligned = (target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) state <= S_RST;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      S_RST:   state_nxt = S_FETCH;
      S_FETCH: if (imem_ready) state_nxt = S_EXEC;
      S_EXEC:  if (!hold)      state_nxt = misaligned ? S_TRAP : S_FETCH;
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      instr   <= NOP_INSTR;
      trap    <= 1'b0;
      trap_pc <= 32'd0;
      instret <= 32'd0;
    end else begin
      if (fetch_done)
        instr <= imem_rdata;
      if (retire) begin
        instret <= instret + 32'd1;
        if (misaligned) begin
          // pc keeps pointing at the faulting instruction.
          trap    <= 1'b1;
          trap_pc <= target;
        end else begin
          pc <= target;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus randomized
// fetch/execute traffic compared against a simple architectural PC model.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        hold, branch, jal, jalr, zero;
  logic [31:0] alu_result;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc, pc_plus4;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] instret;

  int vectors = 0;
  int miscompares = 0;

  // architectural model
  logic [31:0] m_pc, m_instr, m_instret, m_trap_pc;
  logic        m_trap;

  ifetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .hold(hold), .branch(branch), .jal(jal), .jalr(jalr), .zero(zero),
    .alu_result(alu_result),
    .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .trap(trap), .trap_pc(trap_pc), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_ctrl();
    branch = 0; jal = 0; jalr = 0; zero = 0; alu_result = 32'd0;
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = NOP_INSTR; m_instret = 0; m_trap = 0; m_trap_pc = 0;
  endtask

  task automatic check_reset_state();
    check("rst_pc",      pc,          RESET_PC);
    check("rst_instr",   instr,       NOP_INSTR);
    check("rst_valid",   instr_valid, 0);
    check("rst_req",     imem_req,    0);
    check("rst_trap",    trap,        0);
    check("rst_trap_pc", trap_pc,     0);
    check("rst_instret", instret,     0);
  endtask

  // Called while the DUT is in a fetch slot (imem_req expected high).
  task automatic fetch(input int waits, input logic [31:0] word);
    for (int i = 0; i < waits; i++) begin
      imem_ready = 0;
      imem_rdata = $urandom;
      check("wait_req",   imem_req,    1);
      check("wait_addr",  imem_addr,   m_pc);
      check("wait_valid", instr_valid, 0);
      tick();
    end
    imem_ready = 1;
    imem_rdata = word;
    check("fetch_req",  imem_req,  1);
    check("fetch_addr", imem_addr, m_pc);
    tick();
    // ready outside the fetch slot must be ignored
    imem_ready = $urandom_range(0, 1);
    imem_rdata = $urandom;
    m_instr = word;
    check("exec_instr", instr,       m_instr);
    check("exec_valid", instr_valid, 1);
    check("exec_req",   imem_req,    0);
    check("exec_pc",    pc,          m_pc);
    check("exec_pc4",   pc_plus4,    m_pc + 32'd4);
  endtask

  task automatic exec(input int holds, input logic br, input logic jl, input logic jr,
                      input logic z, input logic [31:0] alu);
    logic [31:0] tgt;
    for (int i = 0; i < holds; i++) begin
      hold = 1;
      branch = $urandom_range(0, 1); jal = $urandom_range(0, 1);
      jalr = $urandom_range(0, 1);   zero = $urandom_range(0, 1);
      alu_result = $urandom;
      tick();
      check("hold_pc",      pc,          m_pc);
      check("hold_instr",   instr,       m_instr);
      check("hold_instret", instret,     m_instret);
      check("hold_valid",   instr_valid, 1);
    end
    hold = 0;
    branch = br; jal = jl; jalr = jr; zero = z; alu_result = alu;
    if (jr)                 tgt = alu & 32'hFFFF_FFFE;
    else if ((br && z) || jl) tgt = m_pc + alu;
    else                    tgt = m_pc + 32'd4;
    tick();
    clear_ctrl();
    imem_ready = 0;
    m_instret = m_instret + 1;
    if (tgt[1:0] != 2'b00) begin
      m_trap = 1; m_trap_pc = tgt;
    end else begin
      m_pc = tgt;
    end
    check("ret_instret", instret, m_instret);
    check("ret_pc",      pc,      m_pc);
    check("ret_trap",    trap,    m_trap);
    check("ret_valid",   instr_valid, 0);
    if (m_trap) begin
      check("ret_trap_pc", trap_pc,  m_trap_pc);
      check("ret_req_trap", imem_req, 0);
    end else begin
      check("ret_req",  imem_req,  1);
      check("ret_addr", imem_addr, m_pc);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic        c_br, c_jl, c_jr, c_z;

    rst_n = 0; imem_ready = 1; imem_rdata = 32'hDEAD_BEEF; hold = 0;
    clear_ctrl();
    model_reset();
    tick(); tick();
    check_reset_state();
    rst_n = 1;
    imem_ready = 0;
    tick();
    check("first_req",  imem_req,  1);
    check("first_addr", imem_addr, RESET_PC);

    // sequential fetch, zero-wait, 2 cycles per instruction
    for (int i = 0; i < 3; i++) begin
      fetch(0, $urandom);
      exec(0, 0, 0, 0, 0, 32'd0);
    end
    check("seq_instret3", instret, 32'd3);

    // wait states then fall through to pc=0x10
    fetch(3, 32'h0050_0093);
    exec(0, 0, 0, 0, 0, 32'd0);
    check("pc_is_10", pc, 32'h10);

    // taken branch 0x10 -> 0x08, walk back to 0x10, not-taken -> 0x14
    fetch(0, $urandom); exec(0, 1, 0, 0, 1, 32'hFFFF_FFF8);
    check("br_taken", pc, 32'h08);
    fetch(0, $urandom); exec(0, 0, 0, 0, 0, 32'd0);
    fetch(1, $urandom); exec(0, 0, 0, 0, 0, 32'd0);
    fetch(0, $urandom); exec(0, 1, 0, 0, 0, 32'hFFFF_FFF8);
    check("br_not_taken", pc, 32'h14);

    // jal to 0x20, jalr 0x101 -> 0x100, back to 0x20, jal +0x40, jal+jalr
    fetch(0, $urandom); exec(0, 0, 1, 0, 0, 32'h0000_000C);
    check("jal_to_20", pc, 32'h20);
    fetch(0, $urandom); exec(0, 0, 0, 1, 0, 32'h0000_0101);
    check("jalr_100", pc, 32'h100);
    fetch(0, $urandom); exec(0, 0, 0, 1, 0, 32'h0000_0020);
    fetch(0, $urandom); exec(0, 0, 1, 0, 0, 32'h0000_0040);
    check("jal_60", pc, 32'h60);
    fetch(0, $urandom); exec(0, 1, 1, 1, 1, 32'h0000_0200);
    check("jal_jalr_prio", pc, 32'h200);

    // wrap 0xFFFF_FFFC -> 0
    fetch(0, $urandom); exec(0, 0, 0, 1, 0, 32'hFFFF_FFFC);
    fetch(0, $urandom); exec(0, 0, 0, 0, 0, 32'd0);
    check("pc_wrap", pc, 32'h0);

    // randomized aligned traffic
    for (int i = 0; i < 25; i++) begin
      c_br = $urandom_range(0, 1); c_jl = $urandom_range(0, 1);
      c_jr = $urandom_range(0, 1); c_z  = $urandom_range(0, 1);
      a = $urandom & 32'hFFFF_FFFC;
      if (c_jr) a = a | 32'($urandom_range(0, 1));
      fetch($urandom_range(0, 2), $urandom);
      exec($urandom_range(0, 2), c_br, c_jl, c_jr, c_z, a);
    end

    // long hold, then misaligned jalr traps
    fetch(0, $urandom);
    exec(5, 0, 0, 1, 0, 32'h0000_0106);
    check("trap_pc_106", trap_pc, 32'h106);
    imem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("trap_sticky", trap,        1);
      check("trap_req",    imem_req,    0);
      check("trap_valid",  instr_valid, 0);
      check("trap_pc_hold", pc,         m_pc);
    end

    // recover via reset, retire one, then reset mid-handshake
    rst_n = 0; imem_ready = 0;
    tick();
    model_reset();
    check_reset_state();
    rst_n = 1;
    tick();
    fetch(0, 32'h1234_5678);
    exec(0, 0, 0, 0, 0, 32'd0);
    check("pre_rst_pc", pc, 32'h4);
    imem_ready = 1; imem_rdata = 32'hCAFE_F00D; rst_n = 0;
    tick();
    model_reset();
    check_reset_state();
    rst_n = 1; imem_ready = 0;
    tick();
    check("post_rst_req",  imem_req,  1);
    check("post_rst_addr", imem_addr, RESET_PC);
    fetch(1, 32'h0000_0013);
    exec(0, 0, 0, 0, 0, 32'd0);
    check("post_rst_instret", instret, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
